// File: rtl/multicycle_seq.sv
// multicycle_seq: FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port, with retire counter
module multicycle_seq #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             branch_sig,
  input  logic             jump,
  input  logic             is_system,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             rf_we,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [2:0] WB     = 3'd5;
  localparam logic [2:0] HALT   = 3'd6;
  logic [2:0] nxt;
  logic       in_fetch, in_mem, in_wb;
  always_comb begin
    nxt = state == IDLE   ? (run ? FETCH : IDLE) :
          state == FETCH  ? (mem_ready ? DECODE : FETCH) :
          state == DECODE ? (is_system ? HALT : EXEC) :
          state == EXEC   ? ((mem_read | mem_write) ? MEM : WB) :
          state == MEM    ? (mem_ready ? WB : MEM) :
          state == WB     ? (run ? FETCH : IDLE) :
          state == HALT   ? HALT : IDLE;
  end
  assign in_fetch     = state == FETCH;
  assign in_mem       = state == MEM;
  assign in_wb        = state == WB;
  assign mem_req      = in_fetch | in_mem;
  assign mem_addr_sel = in_mem;
  assign mem_we       = in_mem & mem_write;
  assign ir_we        = in_fetch & mem_ready;
  assign pc_we        = in_wb;
  assign pc_src       = in_wb & (jump | (branch_sig & branch_taken));
  assign rf_we        = in_wb & ~(mem_write | branch_sig);
  assign halted       = state == HALT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      instret <= '0;
    end else begin
      state <= nxt;
      if (in_wb) instret <= instret + CNT_W'(1);
    end
  end
endmodule
